// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Word-addressed memory responder for the multicycle CPU request port.
// It takes one request at a time. It waits LATENCY cycles and then returns
// either read data or a write completion, together with an error flag.
//
// Request/response handshake:
//   A request transfers on a rising edge where req_valid && req_ready.
//   A response transfers on a rising edge where rsp_valid && rsp_ready.
//   Once rsp_valid is high, it stays high with stable rsp_rdata/rsp_err
//   until the transfer happens. req_ready and rsp_valid are never high
//   together, so at most one request is ever outstanding.
module cpu_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // The wait counter is 4 bits wide, and the word index must fit in the address.
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("cpu_mem_responder: LATENCY must be within 0..15");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 30) begin : g_bad_depth
    $error("cpu_mem_responder: DEPTH_LOG2 must be within 1..30");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // The storage array is deliberately left without a reset.
  logic [31:0] mem_q [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wstrb;
  logic [31:0]           word_addr;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  mem_we;
  logic [31:0]           rsp_rdata_d;

  // Select which access to perform. With LATENCY == 0 the commit happens on
  // the accepting edge, so the live request inputs are used. Otherwise the
  // latched copy of the request is used.
  always_comb begin
    accept      = req_valid && req_ready_q && (state_q == ST_IDLE);
    commit      = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                  ((LATENCY == 0) && accept);
    acc_we      = (state_q == ST_IDLE) ? req_we    : we_q;
    acc_addr    = (state_q == ST_IDLE) ? req_addr  : addr_q;
    acc_wdata   = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    acc_wstrb   = (state_q == ST_IDLE) ? req_wstrb : wstrb_q;
    word_addr   = {2'b00, acc_addr[31:2]};
    acc_err     = (acc_addr[1:0] != 2'b00) || (word_addr >= 32'(DEPTH));
    acc_idx     = acc_addr[DEPTH_LOG2+1:2];
    // The resetn gate stops a write from committing while reset is asserted.
    mem_we      = commit && acc_we && !acc_err && resetn;
    rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : mem_q[acc_idx];
  end

  // Byte-enabled write into the array. It takes effect on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
// This bench drives two instances. The first uses LATENCY=2 and covers the
// table vectors, random traffic, backpressure and mid-operation reset. The
// second uses LATENCY=0 and covers back-to-back streaming.
module tb_cpu_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        resetn;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_wstrb;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  logic [1:0]  z_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {err, rdata} is expected in request order.
  logic [32:0] exp_q[$];

  // Reference memory contents, kept as a flat word array.
  logic [31:0] model_mem [0:1023];

  // Stream tables for the LATENCY=0 instance.
  logic [31:0] s_addr  [0:7];
  logic [31:0] s_wdata [0:7];
  logic [31:0] s_exp   [0:7];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [0:16];

  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut_z (
    .clk(clk), .resetn(resetn),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model derived from the access rules.
  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [32:0] exp);
    int idx;
    logic [31:0] w;
    if ((a % 4 != 0) || (a / 4 >= 1024)) begin
      exp = {1'b1, 32'd0};
    end else begin
      idx = int'(a / 4);
      if (we) begin
        w = model_mem[idx];
        for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
        model_mem[idx] = w;
        exp = 33'd0;
      end else begin
        exp = {1'b0, model_mem[idx]};
      end
    end
  endtask

  // Driver for the LATENCY=2 instance. It issues one request and checks
  // latency, the handshake exclusivity and stability under bp cycles of
  // backpressure. When inject is set, a competing write to 0x40 is
  // offered during the backpressure cycles.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int bp, input bit inject);
    logic [32:0] exp;
    int lat;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    exp = exp_q.pop_front();
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      check("req_ready_wait", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid expected after %0d edges", LAT);
      return;
    end
    check("latency", lat, LAT);
    check("ready_with_valid", {31'd0, req_ready}, 32'd0);
    check("rsp_rdata", rsp_rdata, exp[31:0]);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp[32]});
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      if (inject) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h5A5A_A5A5;
        req_wstrb = 4'hF;
      end
      @(posedge clk); #1;
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, exp[31:0]);
      check("bp_err", {31'd0, rsp_err}, {31'd0, exp[32]});
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  // Issue a request that also goes through the reference model.
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int bp, input bit inject);
    logic [32:0] exp;
    model_access(we, addr, wdata, wstrb, exp);
    exp_q.push_back(exp);
    txn(we, addr, wdata, wstrb, bp, inject);
  endtask

  // Back-to-back stream on the LATENCY=0 instance, with valid and ready held high.
  task automatic stream(input logic we, input int n);
    int k, got, last_cyc;
    bit acc;
    k = 0;
    got = 0;
    last_cyc = 0;
    z_req_we    = we;
    z_req_addr  = s_addr[0];
    z_req_wdata = s_wdata[0];
    z_req_wstrb = 4'hF;
    z_req_valid = 1'b1;
    z_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 8 * n + 10 && got < n; cyc++) begin
      acc = z_req_valid && z_req_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k >= n) z_req_valid = 1'b0;
        else begin
          z_req_addr  = s_addr[k];
          z_req_wdata = s_wdata[k];
        end
      end
      check("z_excl", {31'd0, z_req_ready && z_rsp_valid}, 32'd0);
      if (z_rsp_valid) begin
        check("z_rdata", z_rsp_rdata, we ? 32'd0 : s_exp[got]);
        check("z_err", {31'd0, z_rsp_err}, 32'd0);
        if (got > 0) check("z_spacing", cyc - last_cyc, 2);
        last_cyc = cyc;
        got++;
      end
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    check("z_count", got, n);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    int ord [0:5];

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0024, 32'h5566_7788, 4'hF, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h5566_7788, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_C0DE, 1'b0};
    vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_0002, 32'h7777_7777, 4'hF, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};

    // Reset phase.
    resetn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
    z_req_wstrb = 4'd0; z_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_state_idle", {30'd0, dbg_state}, 32'd0);
    check("rst_z_req_ready", {31'd0, z_req_ready}, 32'd1);
    check("rst_z_rsp_valid", {31'd0, z_rsp_valid}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors. The model runs alongside so that its memory
    // stays consistent with the DUT.
    for (int i = 0; i <= 16; i++) begin
      logic [32:0] dummy;
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, dummy);
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 1'b0);
    end

    // Initialise words 0..31 and then run random mixed traffic.
    for (int w = 0; w < 32; w++) begin
      model_txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 31) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else             a = 32'h1000 + 32'($urandom_range(0, 1000) * 4);
      model_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), 1'b0);
    end

    // Backpressure for 7 cycles while a competing write to 0x40 is offered.
    // That write must be ignored.
    model_txn(1'b0, 32'h48, 32'd0, 4'd0, 7, 1'b1);
    model_txn(1'b1, 32'h4C, 32'h0F0F_1234, 4'hF, 7, 1'b1);
    model_txn(1'b0, 32'h40, 32'd0, 4'd0, 0, 1'b0);
    model_txn(1'b0, 32'h13, 32'd0, 4'd0, 7, 1'b0);

    // Reset in the middle of WAIT drops an uncommitted write.
    model_txn(1'b1, 32'h44, 32'h1357_9BDF, 4'hF, 0, 1'b0);
    model_txn(1'b0, 32'h44, 32'd0, 4'd0, 0, 1'b0);
    check("mw_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h2468_ACE0;
    req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mw_in_wait", {31'd0, rsp_valid}, 32'd0);
    resetn = 1'b0;
    #1;
    check("mr_req_ready", {31'd0, req_ready}, 32'd1);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("mr_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("mr2_req_ready", {31'd0, req_ready}, 32'd1);
    check("mr2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr2_rsp_rdata", rsp_rdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    model_txn(1'b0, 32'h44, 32'd0, 4'd0, 0, 1'b0);
    model_txn(1'b0, 32'h10, 32'd0, 4'd0, 0, 1'b0);

    // Streaming on the LATENCY=0 instance: writes first, then reads in a
    // permuted order.
    for (int i = 0; i < 6; i++) begin
      s_addr[i]  = 32'(i * 4);
      s_wdata[i] = $urandom;
    end
    stream(1'b1, 6);
    ord[0] = 3; ord[1] = 0; ord[2] = 5; ord[3] = 1; ord[4] = 4; ord[5] = 2;
    for (int i = 0; i < 6; i++) begin
      s_exp[i]  = s_wdata[ord[i]];
      s_addr[i] = 32'(ord[i] * 4);
    end
    stream(1'b0, 6);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
